// File: rtl/mem_byte_sequencer_if.sv
// Byte-wide req/ack memory bus between the memory-stage sequencer and data memory.
//   bus_req   : byte transfer request (master -> slave)
//   bus_we    : 1 = write byte
//   bus_addr  : byte address of the current transfer
//   bus_wdata : write byte
//   bus_rdata : read byte (slave -> master)
//   bus_ack   : transfer accepted/completed this cycle
interface mem_byte_sequencer_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [7:0]  bus_wdata;
   logic [7:0]  bus_rdata;
   logic        bus_ack;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata,
      input  bus_rdata, bus_ack
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata,
      output bus_rdata, bus_ack
   );
endinterface

// File: rtl/mem_byte_sequencer.sv
// Data-memory access stage: turns a byte/half/word load or store from the
// decoder into big-endian byte transfers on an 8-bit req/ack bus, stalls the
// core while the access is in flight and returns extended load data.
//   clk, rst          : clock (rising edge), async active-high reset
//   valid             : memory-stage instruction valid
//   MemRead, MemWrite : size codes 0=none 1=byte 2=half 3=word
//   addr, wdata       : byte address and right-justified store data
//   rdata             : registered load result, held until next completed load
//   stall             : freeze upstream pipeline
//   done, fault       : one-cycle completion / error pulses
//   bus               : byte memory bus (master side)
module mem_byte_sequencer #(
   parameter bit SIGN_EXT = 1'b1,
   parameter int TIMEOUT  = 16
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        valid,
   input  logic [1:0]                  MemRead,
   input  logic [1:0]                  MemWrite,
   input  logic [31:0]                 addr,
   input  logic [31:0]                 wdata,
   output logic [31:0]                 rdata,
   output logic                        stall,
   output logic                        done,
   output logic                        fault,
   mem_byte_sequencer_if.master        bus
);

   localparam int TW   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam int TLIM = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
   localparam logic [TW-1:0] TLIM_V = TW'(TLIM);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t        state, state_nx;
   logic [1:0]    k_q, last_q, size_q;
   logic          dir_q;
   logic [31:0]   addr_q, wdata_q, asm_q;
   logic [31:0]   asm_nx;
   logic [TW-1:0] tcnt_q;
   logic          fault_q;

   logic          req, both, aligned, legal, illegal, accept, expire;
   logic [1:0]    size_in;

   // Sign/zero extension of the assembled load value by access size.
   function automatic logic [31:0] load_ext(input logic [31:0] raw, input logic [1:0] sz);
      logic signed [7:0]  b;
      logic signed [15:0] h;
      logic signed [31:0] r;
      b = raw[7:0];
      h = raw[15:0];
      case (sz)
         2'd1:    r = SIGN_EXT ? 32'(b) : {24'd0, raw[7:0]};
         2'd2:    r = SIGN_EXT ? 32'(h) : {16'd0, raw[15:0]};
         default: r = raw;
      endcase
      return r;
   endfunction

   // sel counts bytes from the least significant end, so big-endian index k
   // of an N-byte access maps to sel = (N-1) - k.
   function automatic logic [7:0] store_byte(input logic [31:0] w, input logic [1:0] sel);
      case (sel)
         2'd0:    return w[7:0];
         2'd1:    return w[15:8];
         2'd2:    return w[23:16];
         default: return w[31:24];
      endcase
   endfunction

   // Request decode
   assign size_in = (MemRead != 2'd0) ? MemRead : MemWrite;
   assign req     = valid && ((MemRead != 2'd0) || (MemWrite != 2'd0));
   assign both    = (MemRead != 2'd0) && (MemWrite != 2'd0);
   assign aligned = (size_in == 2'd3) ? (addr[1:0] == 2'b00) :
                    (size_in == 2'd2) ? (addr[0] == 1'b0) : 1'b1;
   assign legal   = req && !both && aligned;
   assign illegal = req && !legal;
   assign expire  = (TIMEOUT > 0) && (tcnt_q == TLIM_V);
   assign asm_nx  = {asm_q[23:0], bus.bus_rdata};
   assign fault   = fault_q;

   always_comb begin
      state_nx      = state;
      accept        = 1'b0;
      stall         = 1'b0;
      done          = 1'b0;
      bus.bus_req   = 1'b0;
      bus.bus_we    = 1'b0;
      bus.bus_addr  = 32'd0;
      bus.bus_wdata = 8'd0;
      case (state)
         IDLE: begin
            if (legal) begin
               stall    = 1'b1;
               accept   = 1'b1;
               state_nx = XFER;
            end
         end
         XFER: begin
            stall         = 1'b1;
            bus.bus_req   = 1'b1;
            bus.bus_we    = dir_q;
            bus.bus_addr  = addr_q + {30'd0, k_q};
            bus.bus_wdata = store_byte(wdata_q, last_q - k_q);
            if (bus.bus_ack) begin
               if (k_q == last_q) state_nx = DONE;
            end else if (expire) begin
               state_nx = IDLE;
            end
         end
         DONE: begin
            done     = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
      if (rst) stall = 1'b0;
   end

   // Control state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         k_q     <= 2'd0;
         tcnt_q  <= '0;
         fault_q <= 1'b0;
         rdata   <= 32'd0;
      end else begin
         state   <= state_nx;
         fault_q <= ((state == IDLE) && illegal) ||
                    ((state == XFER) && !bus.bus_ack && expire);
         if (accept) begin
            k_q    <= 2'd0;
            tcnt_q <= '0;
         end else if (state == XFER) begin
            if (bus.bus_ack) begin
               tcnt_q <= '0;
               if (k_q != last_q) k_q <= k_q + 2'd1;
               else if (!dir_q)   rdata <= load_ext(asm_nx, size_q);
            end else begin
               tcnt_q <= tcnt_q + 1'b1;
            end
         end
      end
   end

   // Latched access descriptor and load assembly
   always_ff @(posedge clk) begin
      if (accept) begin
         addr_q  <= addr;
         wdata_q <= wdata;
         size_q  <= size_in;
         dir_q   <= (MemWrite != 2'd0);
         last_q  <= (size_in == 2'd3) ? 2'd3 : size_in - 2'd1;
      end
      if ((state == XFER) && bus.bus_ack && !dir_q) asm_q <= asm_nx;
   end

endmodule

// File: doc/mem_byte_sequencer.md
Name: mem_byte_sequencer

Overview:
- Data-memory access stage downstream of the main control decoder.
- Consumes the 2-bit MemRead/MemWrite size codes (0=none, 1=byte, 2=half, 3=word), the ALU-computed address and the rt store data.
- Serialises each access into big-endian byte transfers on an 8-bit req/ack memory bus.
- Stalls the core until the access completes and returns sign-extended load data.

Parameters:
- SIGN_EXT, 1, 1 = sign-extend lb/lh results; 0 = zero-extend.
- TIMEOUT, 16, max cycles waiting for bus_ack on one byte before aborting with fault; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  reset, asynchronous, active-high
- valid  input  1  instruction in memory stage is valid
- MemRead  input  2  load size code
- MemWrite  input  2  store size code
- addr  input  32  byte address
- wdata  input  32  store data (right-justified)
- rdata  output  32  load result, registered, held until the next completed load
- stall  output  1  freeze upstream pipeline
- done  output  1  one-cycle pulse: access complete
- fault  output  1  one-cycle pulse: misaligned, illegal or timed-out access
- bus_req  output  1  byte transfer request
- bus_we  output  1  1 = write byte
- bus_addr  output  32  byte address on the bus
- bus_wdata  output  8  write byte
- bus_rdata  input  8  read byte
- bus_ack  input  1  transfer accepted/completed this cycle

Behaviour:
- Reset (async, active-high):
  - state=IDLE; byte counter and timeout counter = 0.
  - rdata, done, fault, bus_req, bus_we, bus_addr, bus_wdata all 0.
  - stall is forced 0 while rst is high.
  - Asserting rst mid-transfer drops bus_req immediately and discards the partial access.
- States: IDLE, XFER, DONE.
- IDLE: a request exists when valid=1 and (MemRead≠0 or MemWrite≠0).
  - Legal request: exactly one of MemRead/MemWrite ≠ 0, and aligned (half: addr[0]=0; word: addr[1:0]=0).
  - Legal: stall=1 combinationally in the same cycle. Latch addr, wdata, size, direction; N = 1/2/4 bytes; go to XFER.
  - Illegal (misaligned, or both codes ≠ 0): fault=1 for the next cycle only, no bus activity, stall stays 0, remain IDLE.
- XFER:
  - stall=1 and bus_req=1.
  - bus_addr = latched addr + k, where k is the byte index 0..N-1.
  - bus_we = direction.
  - bus_wdata (big-endian): byte = wdata[7:0]; half k0=[15:8], k1=[7:0]; word k0=[31:24] … k3=[7:0].
  - Outputs stay stable until bus_ack=1 is sampled on a rising edge.
  - On ack, a read shifts bus_rdata into the assembly register (first byte = most significant).
  - Ack with k<N-1: k++ and the next byte is presented the following cycle, with bus_req held high (minimum 1 cycle per byte).
  - Ack with k=N-1: go to DONE.
  - Timeout counter resets on each ack. If TIMEOUT>0 and the counter reaches TIMEOUT without ack: drop bus_req, fault=1 for one cycle, rdata unchanged, go to IDLE (stall drops).
- DONE (one cycle):
  - done=1, stall=0, bus_req=0.
  - For a read, rdata updates at DONE entry: byte → ext(8), half → ext(16), word → as-is, where ext uses the sign bit when SIGN_EXT=1.
  - Writes leave rdata unchanged.
  - valid/size inputs are ignored in DONE; they still describe the completed instruction. Always return to IDLE.
- Latency (ack every cycle): byte 2 cycles of stall-free completion path; N-byte access = N XFER cycles + 1 DONE cycle. Back-to-back accesses have a minimum gap of one IDLE cycle.
- Non-memory instructions (both codes 0) and valid=0: stall=0, no bus activity.

Test Plan:
- Word load, addr=0x100, memory bytes 0x12,0x34,0x56,0x78, ack every cycle:
  - bus_addr 0x100..0x103 on consecutive cycles; stall high 5 cycles incl. accept cycle; done pulse; rdata=0x12345678.
- lb at 0x203 returning 0x80 with SIGN_EXT=1 → rdata=0xFFFFFF80. lh at 0x204 returning 0x7F,0xFE → rdata=0x00007FFE.
- sh wdata=0xDEADBEEF at 0x10, ack delayed 3 cycles per byte:
  - bus_wdata 0xBE @0x10 then 0xEF @0x11; each held stable until ack; bus_we=1; rdata unchanged.
- Misaligned lw at 0x102, and MemRead=1 & MemWrite=1 together:
  - fault single pulse; bus_req never asserts; stall 0.
- TIMEOUT=16, no ack ever → bus_req high exactly 16 cycles, then fault pulse, state IDLE, stall 0.
- Assert rst during byte 2 of a word store → bus_req, stall, done drop asynchronously; a following lw completes normally.
